// File: rtl/antares_gpr_bank_pkg.sv
// rtl/antares_gpr_bank_pkg.sv - shared types and defaults for the Antares GPR bank
package antares_gpr_bank_pkg;

  // Sequencer state encoding: READY = 0, CLEAR = 1
  typedef enum logic {
    GPR_ST_READY = 1'b0,
    GPR_ST_CLEAR = 1'b1
  } gpr_state_e;

  // Default geometry of the bank
  localparam int GPR_DEF_DATA_WIDTH = 32;
  localparam int GPR_DEF_ADDR_WIDTH = 5;

  // First register the clear sequencer touches; r0 is skipped when it is hard-wired
  function automatic int gpr_first_ptr(input bit zero_reg);
    return zero_reg ? 1 : 0;
  endfunction

endpackage

// File: rtl/antares_gpr_clr_seq.sv
// rtl/antares_gpr_clr_seq.sv - clear sequencer that zeroes the register array
module antares_gpr_clr_seq
  import antares_gpr_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_DEF_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(gpr_first_ptr(ZERO_REG));
  localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

  gpr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // State and pointer register; reset (re)starts a clear from FIRST
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GPR_ST_CLEAR;
      ptr_q   <= FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk the pointer to the last register, accept clear requests only in READY
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      GPR_ST_READY: begin
        if (clr_req) begin
          state_d = GPR_ST_CLEAR;
          ptr_d   = FIRST;
        end
      end
      GPR_ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = GPR_ST_READY;
        end
      end
      default: begin
        state_d = GPR_ST_CLEAR;
        ptr_d   = FIRST;
      end
    endcase
  end

  // Outputs: busy also covers the reset window so reads are forced while rst_n is low
  always_comb begin
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    if (!rst_n || state_q == GPR_ST_CLEAR) begin
      busy = 1'b1;
    end
    if (rst_n && state_q == GPR_ST_CLEAR) begin
      clr_we = 1'b1;
    end
  end

endmodule

// File: rtl/antares_gpr_bank.sv
// rtl/antares_gpr_bank.sv - two-read/one-write register bank with bypass and hardware clear
module antares_gpr_bank
  import antares_gpr_bank_pkg::*;
#(
  parameter int DATA_WIDTH   = GPR_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = GPR_DEF_ADDR_WIDTH,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gpr_clr,
  input  logic [ADDR_WIDTH-1:0] gpr_ra_a,
  input  logic [ADDR_WIDTH-1:0] gpr_ra_b,
  input  logic [ADDR_WIDTH-1:0] gpr_wa,
  input  logic [DATA_WIDTH-1:0] gpr_wd,
  input  logic                  gpr_we,
  output logic [DATA_WIDTH-1:0] gpr_rd_a,
  output logic [DATA_WIDTH-1:0] gpr_rd_b,
  output logic                  gpr_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ext_we;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  antares_gpr_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (gpr_clr),
    .busy     (gpr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // External write is taken only in READY, with no clear request and not to a hard-wired r0
  always_comb begin
    ext_we = gpr_we && !gpr_busy && !gpr_clr;
    if (ZERO_REG && gpr_wa == '0) begin
      ext_we = 1'b0;
    end
  end

  // Write-port mux: the sequencer owns the port while clearing
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = gpr_wa;
    wr_data = gpr_wd;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (ext_we) begin
      wr_en = 1'b1;
    end
  end

  // Register array; intentionally not reset, zeros come from the sequencer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A: busy, hard zero, same-cycle bypass, then array
  always_comb begin
    gpr_rd_a = regs[gpr_ra_a];
    if (gpr_busy) begin
      gpr_rd_a = '0;
    end else if (ZERO_REG && gpr_ra_a == '0) begin
      gpr_rd_a = '0;
    end else if (WRITE_BYPASS && gpr_we && !gpr_clr && gpr_ra_a == gpr_wa) begin
      gpr_rd_a = gpr_wd;
    end
  end

  // Read port B: same priority as port A, fully independent
  always_comb begin
    gpr_rd_b = regs[gpr_ra_b];
    if (gpr_busy) begin
      gpr_rd_b = '0;
    end else if (ZERO_REG && gpr_ra_b == '0) begin
      gpr_rd_b = '0;
    end else if (WRITE_BYPASS && gpr_we && !gpr_clr && gpr_ra_b == gpr_wa) begin
      gpr_rd_b = gpr_wd;
    end
  end

endmodule

// File: tb/tb_antares_gpr_bank.sv
// tb/tb_antares_gpr_bank.sv - directed self-checking bench for antares_gpr_bank
module tb_antares_gpr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Shared stimulus for the 32x32 instances
  logic        rst_n, clr, we;
  logic [4:0]  ra_a, ra_b, wa;
  logic [31:0] wd;
  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        busy0, busy1;

  // Stimulus for the 8x16 instance
  logic        s_rst_n, s_clr, s_we;
  logic [2:0]  s_ra_a, s_ra_b, s_wa;
  logic [15:0] s_wd, s_rd_a, s_rd_b;
  logic        s_busy;

  antares_gpr_bank u_dut0 (
    .clk(clk), .rst_n(rst_n), .gpr_clr(clr), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b),
    .gpr_wa(wa), .gpr_wd(wd), .gpr_we(we), .gpr_rd_a(rd_a0), .gpr_rd_b(rd_b0),
    .gpr_busy(busy0)
  );

  antares_gpr_bank #(.ZERO_REG(1'b0), .WRITE_BYPASS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .gpr_clr(clr), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b),
    .gpr_wa(wa), .gpr_wd(wd), .gpr_we(we), .gpr_rd_a(rd_a1), .gpr_rd_b(rd_b1),
    .gpr_busy(busy1)
  );

  antares_gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_dut2 (
    .clk(clk), .rst_n(s_rst_n), .gpr_clr(s_clr), .gpr_ra_a(s_ra_a), .gpr_ra_b(s_ra_b),
    .gpr_wa(s_wa), .gpr_wd(s_wd), .gpr_we(s_we), .gpr_rd_a(s_rd_a), .gpr_rd_b(s_rd_b),
    .gpr_busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles of both 32-entry instances until both are ready (bounded)
  task automatic count_busy(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy0) c0++;
      if (busy1) c1++;
      if (!busy0 && !busy1) break;
      @(posedge clk);
      #1;
    end
  endtask

  int c0, c1, sn;

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; ra_a = '0; ra_b = '0; wa = '0; wd = '0;
    s_rst_n = 1'b0; s_clr = 1'b0; s_we = 1'b0; s_ra_a = '0; s_ra_b = '0; s_wa = '0; s_wd = '0;
    ra_a = 5'd7;
    step();
    step();

    // Reset state: busy high and reads forced to zero
    @(negedge clk);
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_rd_a0", rd_a0, 32'd0);
    check("rst_rd_b1", rd_b1, 32'd0);
    check("rst_s_busy", {31'd0, s_busy}, 32'd1);

    // Small geometry: clear takes 7 cycles; clr held through the final clear edge is ignored
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    s_clr   = 1'b1;
    sn = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_busy) sn++;
      else break;
      @(posedge clk); #1;
    end
    s_clr = 1'b0;
    check("small_clear_cycles", sn, 32'd7);
    @(posedge clk); #1;
    @(negedge clk);
    check("small_clr_at_fall_ignored", {31'd0, s_busy}, 32'd0);
    @(posedge clk); #1;
    s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF;
    step();
    s_we = 1'b0; s_ra_a = 3'd7; s_ra_b = 3'd7;
    @(negedge clk);
    check("small_rd_a_r7", {16'd0, s_rd_a}, 32'h0000BEEF);
    check("small_rd_b_r7", {16'd0, s_rd_b}, 32'h0000BEEF);

    // Reset clear on the 32-entry instances: 31 cycles with hard r0, 32 without
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(c0, c1);
    check("reset_clear_cycles0", c0, 32'd31);
    check("reset_clear_cycles1", c1, 32'd32);
    check("post_clear_r7", rd_a0, 32'd0);

    // Write/read and zero register
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    wa = 5'd0; wd = 32'h12345678;
    step();
    we = 1'b0; ra_a = 5'd5; ra_b = 5'd0;
    @(negedge clk);
    check("wr_rd_a0_r5", rd_a0, 32'hDEADBEEF);
    check("zero_rd_b0_r0", rd_b0, 32'd0);
    check("wr_rd_a1_r5", rd_a1, 32'hDEADBEEF);
    check("nozero_rd_b1_r0", rd_b1, 32'h12345678);

    // Bypass: same-cycle forwarding on both ports, none without bypass
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd9; wd = 32'h11111111;
    step();
    wd = 32'hA5A5A5A5; ra_a = 5'd9; ra_b = 5'd9;
    @(negedge clk);
    check("byp_rd_a0", rd_a0, 32'hA5A5A5A5);
    check("byp_rd_b0", rd_b0, 32'hA5A5A5A5);
    check("nobyp_rd_a1", rd_a1, 32'h11111111);
    check("nobyp_rd_b1", rd_b1, 32'h11111111);
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    check("nobyp_after_rd_a1", rd_a1, 32'hA5A5A5A5);

    // Runtime clear: fill r1..r31, then clear with a simultaneous write
    @(posedge clk); #1;
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = 32'(a);
      step();
    end
    we = 1'b0; ra_a = 5'd3; ra_b = 5'd31;
    @(negedge clk);
    check("fill_r3", rd_a0, 32'd3);
    check("fill_r31", rd_b0, 32'd31);
    @(posedge clk); #1;
    clr = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hFF; ra_a = 5'd3; ra_b = 5'd3;
    @(negedge clk);
    check("clr_blocks_bypass", rd_a0, 32'd3);
    @(posedge clk); #1;
    clr = 1'b0; we = 1'b0;
    count_busy(c0, c1);
    check("rt_clear_cycles0", c0, 32'd31);
    check("rt_clear_cycles1", c1, 32'd32);
    for (int a = 0; a < 32; a++) begin
      @(posedge clk); #1;
      ra_a = 5'(a); ra_b = 5'(a);
      @(negedge clk);
      check($sformatf("rt_zero0_r%0d", a), rd_a0, 32'd0);
      check($sformatf("rt_zero1_r%0d", a), rd_b1, 32'd0);
    end

    // Reset mid-clear: restart gives a further full 31 cycles; writes during busy are lost
    @(posedge clk); #1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 14; i++) step();
    rst_n = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'h0000CAFE;
    step();
    rst_n = 1'b1;
    c0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy0) c0++;
      else begin
        wa = 5'd6; wd = 32'h00000077;
        break;
      end
      @(posedge clk); #1;
      wd = wd + 32'd1;
    end
    check("midclr_restart_cycles", c0, 32'd31);
    step();
    we = 1'b0; ra_a = 5'd4; ra_b = 5'd6;
    @(negedge clk);
    check("busy_write_lost_r4", rd_a0, 32'd0);
    check("first_write_after_busy", rd_b0, 32'h00000077);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
